// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates dcache/icache word requests onto one synchronous
// single-port RAM, inserting LAT wait cycles per word and locking the grant to the dcache across a 2-word block.
module mem_responder #(
    parameter int unsigned LAT = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        ram_en,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic {OWN_D, OWN_I} owner_t;

    state_t           r_state, w_state_nxt;
    owner_t           r_owner, w_owner_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_lock,  w_lock_nxt;
    logic             r_op,    w_op_nxt;
    logic [29:0]      r_addr,  w_addr_nxt;
    logic [31:0]      r_wdata, w_wdata_nxt;

    logic w_d_req;
    logic w_owner_req;
    logic w_issue;
    logic w_resp;
    logic w_unused;

    // Byte-offset bits of the word addresses carry no information here.
    assign w_unused = ^{daddr[1:0], iaddr[1:0]};

    assign w_d_req     = dREN | dWEN;
    assign w_owner_req = (r_owner == OWN_D) ? w_d_req : iREN;

    // NOTE: every signal assigned in this block gets its default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_lock_nxt  = r_lock;
        w_op_nxt    = r_op;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_issue     = 1'b0;
        w_resp      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A lock with no dcache request means the block was abandoned; the icache
                // may then be granted in the same cycle the lock drops.
                if (r_lock && !w_d_req) begin
                    w_lock_nxt = 1'b0;
                end
                if (w_d_req) begin
                    w_owner_nxt = OWN_D;
                    w_addr_nxt  = daddr[31:2];
                    w_op_nxt    = dWEN;
                    w_wdata_nxt = dstore;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = S_WAIT;
                end else if (iREN) begin
                    w_owner_nxt = OWN_I;
                    w_addr_nxt  = iaddr[31:2];
                    w_op_nxt    = 1'b0;
                    w_wdata_nxt = dstore;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_owner_req) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_issue     = nRST;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                if (w_owner_req) begin
                    w_resp = nRST;
                    if (r_owner == OWN_D) begin
                        w_lock_nxt = ~r_addr[0];
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_owner <= OWN_D;
            r_cnt   <= '0;
            r_lock  <= 1'b0;
            r_op    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lock  <= w_lock_nxt;
            r_op    <= w_op_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign ram_en    = w_issue;
    assign ram_wen   = w_issue & r_op;
    assign ram_addr  = w_issue ? {r_addr, 2'b00} : 32'd0;
    assign ram_wdata = w_issue ? r_wdata : 32'd0;

    assign dwait = ~(w_resp & (r_owner == OWN_D));
    assign iwait = ~(w_resp & (r_owner == OWN_I));
    assign dload = (w_resp && r_owner == OWN_D) ? ram_rdata : 32'd0;
    assign iload = (w_resp && r_owner == OWN_I) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LAT=2) with a synchronous RAM model and an access log;
// inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_mem_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dREN, dWEN, iREN;
    logic [31:0] daddr, dstore, iaddr;
    logic        dwait, iwait;
    logic [31:0] dload, iload;
    logic        ram_en, ram_wen;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:1023];
    logic [32:0] acc_q [$];

    int n_checks = 0;
    int n_errors = 0;

    mem_responder #(.LAT(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port RAM: read data valid the cycle after the strobe.
    always @(posedge CLK) begin
        if (ram_en) begin
            acc_q.push_back({ram_wen, ram_addr});
            if (ram_wen) mem[ram_addr[11:2]] <= ram_wdata;
            else         ram_rdata <= mem[ram_addr[11:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h104 >> 2] = 32'h12345678;
        mem[32'h200 >> 2] = 32'hCAFEF00D;
        ram_rdata = 32'd0;

        // Reset held for two edges with a dcache read already pending.
        nRST = 1'b0; dREN = 1'b1; dWEN = 1'b0; iREN = 1'b0;
        daddr = 32'h100; dstore = 32'd0; iaddr = 32'd0;
        #1;
        check("rst_pre_dwait", dwait, 1'b1);
        check("rst_pre_ram_en", ram_en, 1'b0);
        next_cycle();
        mid();
        check("rst_dwait", dwait, 1'b1);
        check("rst_iwait", iwait, 1'b1);
        check("rst_ram_en", ram_en, 1'b0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_dload", dload, 32'd0);
        next_cycle();
        nRST = 1'b1;

        // Single dcache read of 0x100, request seen at cycle 0.
        for (int c = 0; c < 5; c++) begin
            if (c == 4) dREN = 1'b0;
            mid();
            if (c < 2) check($sformatf("rd_c%0d_ram_en", c), ram_en, 1'b0);
            if (c == 2) begin
                check("rd_c2_ram_en", ram_en, 1'b1);
                check("rd_c2_ram_wen", ram_wen, 1'b0);
                check("rd_c2_ram_addr", ram_addr, 32'h100);
                check("rd_c2_dwait", dwait, 1'b1);
            end
            if (c == 3) begin
                check("rd_c3_dwait", dwait, 1'b0);
                check("rd_c3_dload", dload, 32'hDEADBEEF);
                check("rd_c3_iwait", iwait, 1'b1);
            end
            if (c == 4) check("rd_c4_dwait", dwait, 1'b1);
            next_cycle();
        end

        // Simultaneous requests: dcache first, icache granted at cycle 4.
        dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h200;
        for (int c = 0; c < 9; c++) begin
            if (c == 4) dREN = 1'b0;
            if (c == 8) iREN = 1'b0;
            mid();
            if (c == 3) begin
                check("arb_c3_dwait", dwait, 1'b0);
                check("arb_c3_iwait", iwait, 1'b1);
            end
            if (c == 5) check("arb_c5_ram_en", ram_en, 1'b0);
            if (c == 6) begin
                check("arb_c6_ram_en", ram_en, 1'b1);
                check("arb_c6_ram_addr", ram_addr, 32'h200);
            end
            if (c == 7) begin
                check("arb_c7_iwait", iwait, 1'b0);
                check("arb_c7_iload", iload, 32'hCAFEF00D);
                check("arb_c7_dload", dload, 32'd0);
            end
            next_cycle();
        end

        // Two-word dcache block write with the icache waiting throughout.
        acc_q.delete();
        dWEN = 1'b1; daddr = 32'h40; dstore = 32'h11; iREN = 1'b1; iaddr = 32'h200;
        for (int c = 0; c < 13; c++) begin
            if (c == 4) begin daddr = 32'h44; dstore = 32'h22; end
            if (c == 8) dWEN = 1'b0;
            if (c == 12) iREN = 1'b0;
            mid();
            if (c == 2) begin
                check("blk_c2_ram_wen", ram_wen, 1'b1);
                check("blk_c2_ram_addr", ram_addr, 32'h40);
                check("blk_c2_ram_wdata", ram_wdata, 32'h11);
            end
            if (c == 3) check("blk_c3_dwait", dwait, 1'b0);
            if (c == 6) begin
                check("blk_c6_ram_wen", ram_wen, 1'b1);
                check("blk_c6_ram_addr", ram_addr, 32'h44);
                check("blk_c6_ram_wdata", ram_wdata, 32'h22);
            end
            if (c == 7) begin
                check("blk_c7_dwait", dwait, 1'b0);
                check("blk_c7_iwait", iwait, 1'b1);
            end
            if (c == 10) begin
                check("blk_c10_ram_addr", ram_addr, 32'h200);
                check("blk_c10_ram_wen", ram_wen, 1'b0);
            end
            if (c == 11) check("blk_c11_iwait", iwait, 1'b0);
            next_cycle();
        end
        check("blk_acc_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("blk_acc0", acc_q[0], {1'b1, 32'h40});
            check("blk_acc1", acc_q[1], {1'b1, 32'h44});
            check("blk_acc2", acc_q[2], {1'b0, 32'h200});
        end
        check("blk_mem40", mem[32'h40 >> 2], 32'h11);
        check("blk_mem44", mem[32'h44 >> 2], 32'h22);

        // Abort: read dropped in WAIT, then a fresh request proves IDLE at cycle 2.
        acc_q.delete();
        dREN = 1'b1; daddr = 32'h100;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) dREN = 1'b0;
            if (c == 2) begin dREN = 1'b1; daddr = 32'h104; end
            if (c == 6) dREN = 1'b0;
            mid();
            if (c < 4) begin
                check($sformatf("abt_c%0d_ram_en", c), ram_en, 1'b0);
                check($sformatf("abt_c%0d_dwait", c), dwait, 1'b1);
            end
            if (c == 4) check("abt_c4_ram_addr", ram_addr, 32'h104);
            if (c == 5) begin
                check("abt_c5_dwait", dwait, 1'b0);
                check("abt_c5_dload", dload, 32'h12345678);
            end
            next_cycle();
        end
        check("abt_acc_count", acc_q.size(), 1);

        // dREN and dWEN together: write wins, then read back.
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h8; dstore = 32'h55;
        for (int c = 0; c < 9; c++) begin
            if (c == 4) dWEN = 1'b0;
            if (c == 8) idle_inputs();
            mid();
            if (c == 2) begin
                check("rw_c2_ram_wen", ram_wen, 1'b1);
                check("rw_c2_ram_wdata", ram_wdata, 32'h55);
                check("rw_c2_ram_addr", ram_addr, 32'h8);
            end
            if (c == 3) check("rw_c3_dwait", dwait, 1'b0);
            if (c == 6) check("rw_c6_ram_wen", ram_wen, 1'b0);
            if (c == 7) begin
                check("rw_c7_dwait", dwait, 1'b0);
                check("rw_c7_dload", dload, 32'h55);
            end
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
